umem_port_arbiter: RTL and testbench

- Sequences a single-ported 64-bit unified memory that is shared by two requesters: the uPOWER instruction-fetch stage and the load/store (memory) stage.
- One transaction is outstanding at a time. Arbitration is fixed-priority (data first), with a starvation guard for fetch.
- Drives a stall signal back to the pipeline while any request is unserved.
- Sits between the pipeline's IF/MEM stages and the memory macro, replacing the separate instruction and data arrays.

---
 rtl/umem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_umem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_port_arbiter.sv
// Arbiter and sequencer for one single-ported unified memory shared by the
// instruction-fetch and load/store stages. One transaction in flight at a time.
module umem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner_if;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [STV_W-1:0]  r_starve_cnt;

  logic w_grant;
  logic w_grant_if;
  logic w_starve_full;
  logic w_last_wait;

  // Data has priority; fetch only wins a contested grant once it has been
  // passed over STARVE_MAX times in a row.
  assign w_starve_full = (r_starve_cnt == STV_W'(STARVE_MAX));
  assign w_grant       = (r_state == S_IDLE) && (if_req || d_req);
  assign w_grant_if    = if_req && (!d_req || w_starve_full);
  assign w_last_wait   = (r_state == S_WAIT) && (r_lat_cnt == LAT_W'(1));

  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_last_wait) w_state_next = S_ACK;
      end
      S_ACK: begin
        if_ack       = r_owner_if;
        d_ack        = !r_owner_if;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall     = (if_req && !if_ack) || (d_req && !d_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner_if   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner_if <= w_grant_if;
        r_addr     <= w_grant_if ? if_addr : d_addr;
        r_we       <= !w_grant_if && d_we;
        r_wdata    <= w_grant_if ? '0 : d_wdata;
        if (w_grant_if || !if_req) begin
          r_starve_cnt <= '0;
        end else if (!w_starve_full) begin
          r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
      end
      if (r_state == S_ISSUE) begin
        r_lat_cnt <= LAT_W'(MEM_LAT);
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      // Read data is only valid on the last WAIT cycle; stores leave rdata alone.
      if (w_last_wait && !r_we) begin
        if (r_owner_if) r_if_rdata <= mem_rdata;
        else            r_d_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Bench for umem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_umem_port_arbiter;

  parameter int MEM_LAT    = 2;
  parameter int STARVE_MAX = 4;
  localparam int L = MEM_LAT;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [9:0]  d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        busy;

  umem_port_arbiter #(
    .ADDR_W(10), .DATA_W(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory macro: read data appears MEM_LAT cycles after mem_en, garbage otherwise.
  logic        preload;
  logic [63:0] umem   [0:1023];
  logic [63:0] pipe_d [0:MEM_LAT-1];
  logic        pipe_v [0:MEM_LAT-1];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) umem[i] <= 64'(i);
    end else if (mem_en && mem_we) begin
      umem[mem_addr] <= mem_wdata;
    end
    pipe_v[0] <= mem_en;
    pipe_d[0] <= umem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 64'hBADC_0FFE_E0DD_F00D;

  int n_chk;
  int n_fail;
  int cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction record plus cycles elapsed since its grant.
  logic [63:0] ref_mem [0:1023];
  bit          m_active;
  int          m_k;
  bit          m_own_if;
  logic [9:0]  m_addr;
  bit          m_we;
  logic [63:0] m_wdata;
  logic [63:0] m_result;
  int          m_starve;
  logic [63:0] m_if_rdata;
  logic [63:0] m_d_rdata;

  task automatic model_reset();
    m_active   = 0;
    m_k        = 0;
    m_starve   = 0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
  endtask

  task automatic model_step();
    bit fetch;
    if (m_active) begin
      if (m_k == L + 2) begin
        m_active = 0;
      end else begin
        m_k++;
        if (m_k == L + 2 && !m_we) begin
          if (m_own_if) m_if_rdata = m_result;
          else          m_d_rdata  = m_result;
        end
      end
    end else if (if_req || d_req) begin
      fetch    = if_req && (!d_req || m_starve == STARVE_MAX);
      m_active = 1;
      m_k      = 1;
      m_own_if = fetch;
      m_addr   = fetch ? if_addr : d_addr;
      m_we     = !fetch && d_we;
      m_wdata  = d_wdata;
      m_result = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = d_wdata;
      if (fetch || !if_req) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
  endtask

  // Stimulus controls and observed-event log
  bit          rand_mode;
  bit          dir_hold;
  bit          dir_if_req;
  logic [9:0]  dir_if_addr;
  bit          dir_d_req;
  bit          dir_d_we;
  logic [9:0]  dir_d_addr;
  logic [63:0] dir_d_wdata;
  int          t_if_ack, t_d_ack, t_men, n_grants, n_d_ack;
  logic [63:0] v_if_ack, v_d_ack;
  logic [9:0]  a_men;
  logic        we_men;
  logic [15:0] seq;

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 10'($urandom);
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic drive_random();
    if (if_ack) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = rand_addr();
    end else if (if_req) begin
      if ($urandom_range(0, 19) == 0) if_req = 1'b0;
      if ($urandom_range(0, 7) == 0)  if_addr = rand_addr();
    end else if ($urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
    if (d_ack || (!d_req && $urandom_range(0, 2) == 0)) begin
      d_req   = d_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = rand_addr();
      d_wdata = {$urandom, $urandom};
    end else if (d_req) begin
      if ($urandom_range(0, 19) == 0) d_req = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        d_addr  = rand_addr();
        d_wdata = {$urandom, $urandom};
        d_we    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drive_dir();
    if (if_ack && !dir_hold) dir_if_req = 0;
    if (d_ack && !dir_hold)  dir_d_req  = 0;
    if_req  = dir_if_req;
    if_addr = dir_if_addr;
    d_req   = dir_d_req;
    d_we    = dir_d_we;
    d_addr  = dir_d_addr;
    d_wdata = dir_d_wdata;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check stall, advance model.
  task automatic step();
    bit e_ack;
    @(negedge clk);
    e_ack = m_active && (m_k == L + 2);
    chk("busy", busy, m_active);
    chk("mem_en", mem_en, m_active && m_k == 1);
    if (m_active && m_k == 1) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_ack", if_ack, e_ack && m_own_if);
    chk("d_ack", d_ack, e_ack && !m_own_if);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    if (if_ack) begin
      t_if_ack = cyc; v_if_ack = if_rdata; seq = {seq[14:0], 1'b1}; n_grants++;
    end
    if (d_ack) begin
      t_d_ack = cyc; v_d_ack = d_rdata; seq = {seq[14:0], 1'b0}; n_grants++; n_d_ack++;
    end
    if (mem_en) begin
      t_men = cyc; a_men = mem_addr; we_men = mem_we;
    end
    if (rand_mode) drive_random();
    else           drive_dir();
    #1;
    chk("stall", stall, (if_req && !(e_ack && m_own_if)) || (d_req && !(e_ack && !m_own_if)));
    model_step();
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0;
    dir_if_req = 0; dir_d_req = 0; dir_hold = 0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int t0;
  int t1;
  int d_acks_before;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    reset = 1'b0; preload = 1'b1; rand_mode = 0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    dir_if_addr = '0; dir_d_we = 0; dir_d_addr = '0; dir_d_wdata = '0;
    t_if_ack = -1; t_d_ack = -1; t_men = -1; n_grants = 0; n_d_ack = 0;
    v_if_ack = '0; v_d_ack = '0; a_men = '0; we_men = 1'b0; seq = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 64'(i);
    #2;
    do_reset();
    preload = 1'b0;

    // Single fetch from address 5
    t0 = cyc; dir_if_req = 1; dir_if_addr = 10'd5;
    repeat (L + 4) step();
    chk("t1_men_cycle", 64'(t_men), 64'(t0 + 1));
    chk("t1_men_addr", a_men, 10'd5);
    chk("t1_ack_cycle", 64'(t_if_ack), 64'(t0 + 2 + L));
    chk("t1_if_rdata", v_if_ack, 64'd5);

    // Store 0xAA to 3, then load it back
    t0 = cyc; dir_d_req = 1; dir_d_we = 1; dir_d_addr = 10'd3; dir_d_wdata = 64'hAA;
    repeat (L + 3) step();
    chk("t2_store_we", we_men, 1'b1);
    chk("t2_store_ack", 64'(t_d_ack), 64'(t0 + 2 + L));
    t1 = cyc; dir_d_req = 1; dir_d_we = 0;
    repeat (L + 3) step();
    chk("t2_load_ack", 64'(t_d_ack), 64'(t1 + 2 + L));
    chk("t2_load_data", v_d_ack, 64'hAA);
    chk("t2_if_rdata_kept", if_rdata, 64'd5);

    // Simultaneous requests: data first, fetch follows
    t0 = cyc; dir_if_req = 1; dir_if_addr = 10'd12; dir_d_req = 1; dir_d_we = 0; dir_d_addr = 10'd5;
    repeat (2 * L + 6) step();
    chk("t3_d_ack", 64'(t_d_ack), 64'(t0 + 2 + L));
    chk("t3_f_men", 64'(t_men), 64'(t0 + L + 4));
    chk("t3_if_ack", 64'(t_if_ack), 64'(t0 + 2 * L + 5));
    chk("t3_if_data", v_if_ack, 64'd12);

    // Both held continuously: starvation guard pattern
    seq = '0; n_grants = 0; dir_hold = 1; dir_if_req = 1; dir_d_req = 1;
    for (int i = 0; i < 20 * (L + 3) && n_grants < 10; i++) step();
    dir_hold = 0; dir_if_req = 0; dir_d_req = 0;
    chk("t4_grant_count", 64'(n_grants), 64'd10);
    chk("t4_grant_seq", 64'(seq[9:0]), 64'(10'b0000100001));
    repeat (2) step();

    // Reset during WAIT of a load, then a fresh fetch
    dir_d_req = 1; dir_d_we = 0; dir_d_addr = 10'd7;
    d_acks_before = n_d_ack;
    repeat (2) step();
    @(posedge clk);
    #2;
    do_reset();
    t0 = cyc; dir_if_req = 1; dir_if_addr = 10'd9;
    repeat (L + 3) step();
    chk("t5_no_d_ack", 64'(n_d_ack), 64'(d_acks_before));
    chk("t5_if_ack", 64'(t_if_ack), 64'(t0 + 2 + L));
    chk("t5_if_data", v_if_ack, 64'd9);

    // Randomized traffic
    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0; dir_if_req = 0; dir_d_req = 0;
    repeat (L + 5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
